// File: rtl/count_sequencer.sv
// Run/stop/single-step enable generator for one up-counter: prescaled continuous
// run, single steps, and an optional one-shot stop at a programmed limit.
module count_sequencer #(
    parameter int BITS     = 1,
    parameter int DIV_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_step,
    input  logic                mode_oneshot,
    input  logic [DIV_BITS-1:0] div,
    input  logic [BITS-1:0]     limit,
    input  logic [BITS-1:0]     count_value,
    output logic                count_en,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] pre_q, pre_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic [BITS-1:0]     limit_q, limit_d;
    logic                oneshot_q, oneshot_d;
    logic                tick;
    logic                at_limit;

    assign tick     = (state_q == RUN) && (pre_q == div_q);
    // Terminal detection looks at the value the counter is about to take,
    // so a start with count_value == limit runs a full wrap.
    assign at_limit = ((count_value + BITS'(1)) == limit_q);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        div_d     = div_q;
        limit_d   = limit_q;
        oneshot_d = oneshot_q;
        case (state_q)
            IDLE: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (cmd_step) begin
                    state_d = STEP;
                end else if (cmd_start) begin
                    state_d   = RUN;
                    pre_d     = '0;
                    div_d     = div;
                    limit_d   = limit;
                    oneshot_d = mode_oneshot;
                end
            end
            RUN: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                    pre_d   = '0;
                end else if (tick) begin
                    pre_d = '0;
                    if (oneshot_q && at_limit)
                        state_d = DONE;
                end else begin
                    pre_d = pre_q + DIV_BITS'(1);
                end
            end
            STEP:    state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            div_q     <= '0;
            limit_q   <= '0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            div_q     <= div_d;
            limit_q   <= limit_d;
            oneshot_q <= oneshot_d;
        end
    end

    // Only combinational input-to-output path: stop/reset veto the enable at once.
    assign count_en = (tick || (state_q == STEP)) && !cmd_stop && !rst;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign state    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: drives a 4-bit counter from count_en and checks
// enable timing, state and counter value against arithmetic predictions.
module tb_count_sequencer;

    localparam int BITS     = 4;
    localparam int DIV_BITS = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_start, cmd_stop, cmd_step, mode_oneshot;
    logic [DIV_BITS-1:0] div;
    logic [BITS-1:0]     limit;
    logic [BITS-1:0]     cnt;
    logic                count_en, busy, done;
    logic [1:0]          state;
    logic                load;
    logic [BITS-1:0]     load_val;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.BITS(BITS), .DIV_BITS(DIV_BITS)) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_step(cmd_step),
        .mode_oneshot(mode_oneshot), .div(div), .limit(limit),
        .count_value(cnt),
        .count_en(count_en), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // The controlled counter itself
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (count_en) cnt <= cnt + 4'd1;
    end

    task automatic clear_cmds();
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    endtask

    task automatic load_cnt(input logic [BITS-1:0] v);
        @(negedge clk); load_val = v; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; clear_cmds(); #1;
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b exp 0", count_en); end
        @(negedge clk); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        cmd_start = 1'b1;
        @(negedge clk); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_start_state got %0d exp 0", state); end
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL reset_start_en got %0b exp 0", count_en); end
        rst = 1'b0; cmd_start = 1'b0;
        @(negedge clk); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", state); end
    endtask

    // Free run at div=2: enable every 3rd cycle, 16 increments in 48 cycles wrap the counter.
    task automatic test_freerun();
        logic [BITS-1:0] s;
        s = 4'($urandom_range(0, 15));
        load_cnt(s);
        @(negedge clk); div = 8'd2; mode_oneshot = 1'b0; limit = 4'($urandom); cmd_start = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            cmd_start = 1'($urandom); cmd_step = 1'($urandom);
            div = 8'($urandom); limit = 4'($urandom); mode_oneshot = 1'($urandom);
            #1;
            checks++; if (count_en !== (k % 3 == 2)) begin errors++; $display("FAIL freerun_en k=%0d got %0b exp %0b", k, count_en, (k % 3 == 2)); end
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL freerun_state k=%0d got %0d exp 1", k, state); end
        end
        @(negedge clk); clear_cmds(); cmd_stop = 1'b1; #1;
        checks++; if (cnt !== s) begin errors++; $display("FAIL freerun_wrap got %0d exp %0d", cnt, s); end
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL freerun_stop_en got %0b exp 0", count_en); end
        @(negedge clk); cmd_stop = 1'b0; #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL freerun_idle got %0d exp 0", state); end
    endtask

    task automatic test_oneshot(input logic [BITS-1:0] cv0, input logic [BITS-1:0] lim,
                                input int d, input bit noise);
        int n, last, ens;
        n    = ((int'(lim) - int'(cv0) - 1 + 32) % 16) + 1;
        last = n * (d + 1) - 1;
        ens  = 0;
        load_cnt(cv0);
        @(negedge clk); div = 8'(d); limit = lim; mode_oneshot = 1'b1; cmd_start = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            if (noise) begin
                cmd_start = 1'($urandom); cmd_step = 1'($urandom);
                div = 8'($urandom); limit = 4'($urandom); mode_oneshot = 1'($urandom);
            end
            #1;
            if (count_en === 1'b1) ens++;
            checks++; if (count_en !== (k % (d + 1) == d)) begin errors++; $display("FAIL oneshot_en k=%0d got %0b exp %0b", k, count_en, (k % (d + 1) == d)); end
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL oneshot_run k=%0d got %0d exp 1", k, state); end
        end
        @(negedge clk); cmd_start = 1'($urandom); cmd_step = 1'($urandom); #1;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL oneshot_done_state got %0d exp 3", state); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL oneshot_done got %0b exp 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_done_busy got %0b exp 1", busy); end
        checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL oneshot_done_en got %0b exp 0", count_en); end
        checks++; if (cnt !== lim) begin errors++; $display("FAIL oneshot_cnt got %0d exp %0d", cnt, lim); end
        @(negedge clk); clear_cmds(); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL oneshot_idle got %0d exp 0", state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done_end got %0b exp 0", done); end
        checks++; if (ens !== n) begin errors++; $display("FAIL oneshot_incs got %0d exp %0d", ens, n); end
    endtask

    task automatic test_step();
        logic [BITS-1:0] s;
        s = 4'($urandom_range(0, 15));
        load_cnt(s);
        @(negedge clk); cmd_step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); cmd_step = (k < 5); #1;
            checks++; if (count_en !== (k % 2 == 0)) begin errors++; $display("FAIL step_en k=%0d got %0b exp %0b", k, count_en, (k % 2 == 0)); end
            checks++; if (busy !== (k % 2 == 0)) begin errors++; $display("FAIL step_busy k=%0d got %0b exp %0b", k, busy, (k % 2 == 0)); end
        end
        @(negedge clk); #1;
        checks++; if (cnt !== s + 4'd3) begin errors++; $display("FAIL step_cnt got %0d exp %0d", cnt, s + 4'd3); end
        cmd_step = 1'b1; cmd_start = 1'b1;
        @(negedge clk); clear_cmds(); #1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL step_prio got %0d exp 2", state); end
        checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL step_prio_en got %0b exp 1", count_en); end
        @(negedge clk); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_prio_idle got %0d exp 0", state); end
        checks++; if (cnt !== s + 4'd4) begin errors++; $display("FAIL step_prio_cnt got %0d exp %0d", cnt, s + 4'd4); end
    endtask

    // Abort in a tick cycle with cmd_stop or rst, then confirm a fresh run paces from zero.
    task automatic test_stop(input bit use_rst);
        logic [BITS-1:0] s;
        int j, kstop;
        s = 4'($urandom_range(0, 15));
        j = $urandom_range(0, 3);
        kstop = 2 * j + 1;
        load_cnt(s);
        @(negedge clk); div = 8'd1; mode_oneshot = 1'b0; cmd_start = 1'b1;
        for (int k = 0; k <= kstop; k++) begin
            @(negedge clk); cmd_start = 1'b0;
            if (k == kstop) begin
                if (use_rst) rst = 1'b1; else cmd_stop = 1'b1;
            end
            #1;
            checks++; if (count_en !== (k % 2 == 1 && k != kstop)) begin errors++; $display("FAIL stop_en rst=%0b k=%0d got %0b exp %0b", use_rst, k, count_en, (k % 2 == 1 && k != kstop)); end
        end
        @(negedge clk); rst = 1'b0; cmd_stop = 1'b0; #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_idle rst=%0b got %0d exp 0", use_rst, state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy rst=%0b got %0b exp 0", use_rst, busy); end
        checks++; if (cnt !== s + 4'(j)) begin errors++; $display("FAIL stop_cnt rst=%0b got %0d exp %0d", use_rst, cnt, s + 4'(j)); end
        cmd_start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); cmd_start = 1'b0; #1;
            checks++; if (count_en !== (k == 1)) begin errors++; $display("FAIL restart_en rst=%0b k=%0d got %0b exp %0b", use_rst, k, count_en, (k == 1)); end
        end
        @(negedge clk); cmd_stop = 1'b1; #1;
        @(negedge clk); cmd_stop = 1'b0; #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL restart_idle rst=%0b got %0d exp 0", use_rst, state); end
    endtask

    initial begin
        rst = 1'b1; clear_cmds(); mode_oneshot = 1'b0; div = '0; limit = '0;
        load = 1'b0; load_val = '0;
        test_reset();
        test_freerun();
        test_oneshot(4'd3, 4'd7, 0, 1'b0);
        test_oneshot(4'd5, 4'd5, 0, 1'b0);
        test_step();
        test_stop(1'b0);
        test_stop(1'b1);
        for (int i = 0; i < 6; i++)
            test_oneshot(4'($urandom), 4'($urandom), $urandom_range(0, 4), 1'b1);
        test_freerun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
